// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file port scheduler.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    // Writes here are accepted and discarded; reads of it return zero.
    localparam logic [RF_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-way round-robin arbiter with a one-bit priority pointer.
// The grant is combinational; the pointer moves only on a grant.
module rf_rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic ptr_b;  // set when B wins the next tie

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset) begin
            if (req_a && (!req_b || !ptr_b))
                gnt_a = 1'b1;
            else if (req_b)
                gnt_b = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr_b <= 1'b0;
        else if (gnt_a)
            ptr_b <= 1'b1;
        else if (gnt_b)
            ptr_b <= 1'b0;
    end

endmodule

// File: rtl/rf_port_sched.sv
// Shares the register-file write port between the ALU (A) and load (B) paths
// and issues operand reads, forwarding a write made in the accept cycle.
module rf_port_sched
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic [ADDR_W-1:0] rf_ra1,
    output logic [ADDR_W-1:0] rf_ra2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2
);

    // Request structs carry package widths, so resize the package, not these.
    if (DATA_W != RF_DATA_W || ADDR_W != RF_ADDR_W) begin : g_width_guard
        $error("rf_port_sched widths must match rf_pkg");
    end

    logic    gnt_a, gnt_b;
    wr_req_t req_a, req_b, wr_sel, fwd_q;
    logic    hazard;
    logic    acc_q;
    logic [ADDR_W-1:0] ra1_q, ra2_q;
    logic [DATA_W-1:0] ret1, ret2, hold1, hold2;

    assign req_a = '{valid: a_valid, addr: a_addr, data: a_data};
    assign req_b = '{valid: b_valid, addr: b_addr, data: b_data};

    rf_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req_a (a_valid),
        .req_b (b_valid),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign a_ready = gnt_a;
    assign b_ready = gnt_b;

    always_comb begin
        wr_sel = gnt_b ? req_b : req_a;
        we3    = (gnt_a || gnt_b) && (wr_sel.addr != ZERO_REG);
        wa3    = wr_sel.addr;
        wd3    = wr_sel.data;
    end

    // A waiting (ungranted) write to an operand register would be missed.
    function automatic logic blocks(input logic [ADDR_W-1:0] ra,
                                    input wr_req_t req, input logic gnt);
        return (ra != ZERO_REG) && req.valid && !gnt && (req.addr == ra);
    endfunction

    always_comb begin
        hazard = blocks(ra1, req_a, gnt_a) || blocks(ra1, req_b, gnt_b) ||
                 blocks(ra2, req_a, gnt_a) || blocks(ra2, req_b, gnt_b);
    end

    assign rd_ready = rd_req && !hazard && !reset;
    assign rf_ra1   = ra1;
    assign rf_ra2   = ra2;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= 1'b0;
            ra1_q <= '0;
            ra2_q <= '0;
            fwd_q <= '0;
        end else begin
            acc_q <= rd_ready;
            if (rd_ready) begin
                ra1_q <= ra1;
                ra2_q <= ra2;
                fwd_q <= '{valid: we3, addr: wa3, data: wd3};
            end
        end
    end

    // The register file read at the accept edge misses that cycle's write.
    function automatic logic [DATA_W-1:0] operand(input logic [ADDR_W-1:0] ra,
                                                  input wr_req_t fwd,
                                                  input logic [DATA_W-1:0] rf_rd);
        if (ra == ZERO_REG)
            return '0;
        else if (fwd.valid && fwd.addr == ra)
            return fwd.data;
        else
            return rf_rd;
    endfunction

    assign rd_valid = acc_q && !reset;

    always_comb begin
        ret1 = operand(ra1_q, fwd_q, rf_rd1);
        ret2 = operand(ra2_q, fwd_q, rf_rd2);
        rd1  = rd_valid ? ret1 : hold1;
        rd2  = rd_valid ? ret2 : hold2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold1 <= '0;
            hold2 <= '0;
        end else if (rd_valid) begin
            hold1 <= ret1;
            hold2 <= ret2;
        end
    end

endmodule

// File: tb/tb_rf_port_sched.sv
// Directed bench for rf_port_sched with a behavioural register file
// (registered read, write at the clock edge) hung off the RF ports.
module tb_rf_port_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, rd_req;
    logic [4:0]  a_addr, b_addr, ra1, ra2;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, rd_ready, rd_valid, we3;
    logic [31:0] rd1, rd2, wd3, rf_rd1, rf_rd2;
    logic [4:0]  wa3, rf_ra1, rf_ra2;
    logic [31:0] regs [32];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_port_sched dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rd_req(rd_req), .ra1(ra1), .ra2(ra2), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd1(rd1), .rd2(rd2),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
    );

    always @(posedge clk) begin
        if (we3) regs[wa3] <= wd3;
        rf_rd1 <= regs[rf_ra1];
        rf_rd2 <= regs[rf_ra2];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; rd_req = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0; ra1 = '0; ra2 = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sample();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        idle();

        // Reset held 2 cycles with everything requesting
        reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1; rd_req = 1'b1;
        a_addr = 5'd3; a_data = 32'h33; b_addr = 5'd4; b_data = 32'h44;
        for (int c = 0; c < 2; c++) begin
            wait_sample();
            check("rst_we3", we3, 0);
            check("rst_a_ready", a_ready, 0);
            check("rst_b_ready", b_ready, 0);
            check("rst_rd_ready", rd_ready, 0);
            check("rst_rd_valid", rd_valid, 0);
            check("rst_rd1", rd1, 0);
            next_cycle();
        end

        // Contention: A,B,A,B with unchanging requests
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            wait_sample();
            check("cont_a_ready", a_ready, (c % 2 == 0) ? 1 : 0);
            check("cont_b_ready", b_ready, (c % 2 == 1) ? 1 : 0);
            check("cont_we3", we3, 1);
            check("cont_wa3", wa3, (c % 2 == 0) ? 3 : 4);
            check("cont_wd3", wd3, (c % 2 == 0) ? 32'h33 : 32'h44);
            check("cont_rd_ready", rd_ready, 1);
            if (c > 0) check("cont_rd_valid", rd_valid, 1);
            next_cycle();
        end

        // Forwarding: A writes r5 while r5 is read; r3 comes from the RF
        idle();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        rd_req = 1'b1; ra1 = 5'd5; ra2 = 5'd3;
        wait_sample();
        check("fwd_a_ready", a_ready, 1);
        check("fwd_rd_ready", rd_ready, 1);
        next_cycle();
        idle();
        wait_sample();
        check("fwd_rd_valid", rd_valid, 1);
        check("fwd_rd1", rd1, 32'hDEADBEEF);
        check("fwd_rd2", rd2, 32'h33);
        next_cycle();
        wait_sample();
        check("hold_rd_valid", rd_valid, 0);
        check("hold_rd1", rd1, 32'hDEADBEEF);
        check("hold_rd2", rd2, 32'h33);

        // B alone writes r6, returning priority to A
        next_cycle();
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h66;
        wait_sample();
        check("b_only_ready", b_ready, 1);
        check("b_only_wa3", wa3, 6);
        next_cycle();

        // Hazard stall: read of r7 while B's write to r7 waits behind A
        idle();
        a_valid = 1'b1; a_addr = 5'd8; a_data = 32'h88;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77;
        rd_req = 1'b1; ra1 = 5'd7; ra2 = 5'd8;
        wait_sample();
        check("haz_a_ready", a_ready, 1);
        check("haz_b_ready", b_ready, 0);
        check("haz_rd_ready", rd_ready, 0);
        next_cycle();
        a_valid = 1'b0;
        wait_sample();
        check("haz2_b_ready", b_ready, 1);
        check("haz2_wa3", wa3, 7);
        check("haz2_rd_ready", rd_ready, 1);
        next_cycle();
        idle();
        wait_sample();
        check("haz_ret_valid", rd_valid, 1);
        check("haz_ret_rd1", rd1, 32'h77);
        check("haz_ret_rd2", rd2, 32'h88);
        next_cycle();

        // Register 0: write accepted and dropped, reads return zero
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1234;
        rd_req = 1'b1; ra1 = 5'd0; ra2 = 5'd0;
        wait_sample();
        check("r0_b_ready", b_ready, 1);
        check("r0_we3", we3, 0);
        check("r0_rd_ready", rd_ready, 1);
        next_cycle();
        idle();
        wait_sample();
        check("r0_rd_valid", rd_valid, 1);
        check("r0_rd1", rd1, 0);
        check("r0_rd2", rd2, 0);
        next_cycle();

        // Same address from A then B on consecutive cycles: B wins
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'hA9;
        wait_sample();
        check("waw_a_ready", a_ready, 1);
        next_cycle();
        idle();
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hB9;
        wait_sample();
        check("waw_b_ready", b_ready, 1);
        check("waw_wd3", wd3, 32'hB9);
        next_cycle();
        idle();
        rd_req = 1'b1; ra1 = 5'd9; ra2 = 5'd5;
        wait_sample();
        check("waw_rd_ready", rd_ready, 1);
        next_cycle();
        idle();
        wait_sample();
        check("waw_rd1", rd1, 32'hB9);
        check("waw_rd2", rd2, 32'hDEADBEEF);
        next_cycle();

        // Reset mid-read: accepted in N, reset in N+1 discards the return
        rd_req = 1'b1; ra1 = 5'd4; ra2 = 5'd3;
        wait_sample();
        check("mid_rd_ready", rd_ready, 1);
        next_cycle();
        idle();
        reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd10; b_addr = 5'd11;
        wait_sample();
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_we3", we3, 0);
        next_cycle();
        reset = 1'b0;
        wait_sample();
        check("post_rst_rd_valid", rd_valid, 0);
        check("post_rst_rd1", rd1, 0);
        check("post_rst_a_first", a_ready, 1);
        check("post_rst_b_wait", b_ready, 0);
        next_cycle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
